// File: rtl/reg_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// reg_writeback_arbiter
//
// Write-side companion of the CPU register file. It merges two result sources
// into the register file's single write port (RegWrite/regW/Wdat):
//   - the single-cycle ALU path, which always wins the port;
//   - a long-latency unit (load/mult-div) on a valid/ready handshake, whose
//     results wait in a small FIFO until the ALU leaves the port idle.
// It also answers two "is a write to this register still queued?" queries so
// decode can stall on outstanding long-latency results.
//
// An ALU write to register R makes every queued result for R stale. Those
// entries stay in the FIFO but lose their entry-valid bit, so when they
// reach the head they pop with RegWrite=0. Pushes to r0 are stored the same
// way, already invalid.
//
// Parameters:
//   DEPTH    long-latency FIFO entries (power of two, >= 2)
//   AW       log2(DEPTH)
//
// Ports:
//   clk        clock
//   Rst        synchronous reset, active-high
//   alu_we     ALU result valid this cycle
//   alu_reg    ALU destination register
//   alu_data   ALU result
//   lu_valid   long-latency result offered
//   lu_ready   FIFO can accept (from registered count only)
//   lu_reg     long-latency destination register
//   lu_data    long-latency result
//   qA, qB     pending-query registers
//   busyA/B    a valid queued write to qA/qB exists
//   RegWrite   register-file write enable (registered)
//   regW       register-file write address (registered)
//   Wdat       register-file write data (registered)
//
// Build option:
//   WB_BYPASS_EN  when defined, a long-latency result goes straight to the
//                 output registers if the FIFO is empty, the ALU is idle and
//                 the destination is not r0. Latency is then one cycle.
// -----------------------------------------------------------------------------
module reg_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  input  logic [4:0]  qA,
  input  logic [4:0]  qB,
  output logic        busyA,
  output logic        busyB,
  output logic        RegWrite,
  output logic [4:0]  regW,
  output logic [31:0] Wdat
);

  // FIFO storage and bookkeeping
  logic [4:0]       ent_reg_q  [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  // Write-port output registers
  logic        we_q,    we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic alu_hit;
  logic lu_push;
  logic fifo_empty;
  logic bypass;
  logic fifo_push;
  logic fifo_pop;

  assign alu_hit    = alu_we && (alu_reg != 5'd0);
  assign fifo_empty = (count_q == '0);
  // Ready uses only the registered count; a pop in this cycle does not raise
  // it, which keeps lu_ready free of any path from alu_we.
  assign lu_ready   = (count_q < (AW+1)'(DEPTH));
  assign lu_push    = lu_valid && lu_ready;

`ifdef WB_BYPASS_EN
  assign bypass = fifo_empty && !alu_hit && lu_push && (lu_reg != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = lu_push && !bypass;
  // The FIFO only drains when the ALU leaves the port free.
  assign fifo_pop  = !alu_hit && !fifo_empty;

  // Port arbitration: ALU first, then bypass, then FIFO head.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_hit) begin
      we_d    = 1'b1;
      waddr_d = alu_reg;
      wdata_d = alu_data;
    end else if (bypass) begin
      we_d    = 1'b1;
      waddr_d = lu_reg;
      wdata_d = lu_data;
    end else if (fifo_pop) begin
      // A killed or r0 head still uses up this cycle but writes nothing.
      we_d = ent_vld_q[rd_ptr_q];
      if (ent_vld_q[rd_ptr_q]) begin
        waddr_d = ent_reg_q[rd_ptr_q];
        wdata_d = ent_data_q[rd_ptr_q];
      end
    end
  end

  // Pending query. Popped entries have their valid bit cleared, so a set
  // valid bit also means the slot is occupied.
  always_comb begin
    busyA = 1'b0;
    busyB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[i] && (ent_reg_q[i] == qA) && (qA != 5'd0)) busyA = 1'b1;
      if (ent_vld_q[i] && (ent_reg_q[i] == qB) && (qB != 5'd0)) busyB = 1'b1;
    end
  end

  // Control state. All of it is reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      // NOTE: state uses non-blocking assignments so every flop samples
      // values from before the edge, whatever the order of the statements.
      we_q      <= 1'b0;
      waddr_q   <= 5'd0;
      wdata_q   <= 32'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ent_vld_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;

      if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase

      // Kill stale queued results. A pop never happens in the same cycle
      // as a kill, and the push below comes later in this block. A
      // same-cycle push to the same register is younger, so it stays valid.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_hit && (ent_reg_q[i] == alu_reg)) ent_vld_q[i] <= 1'b0;
      end
      if (fifo_pop)  ent_vld_q[rd_ptr_q] <= 1'b0;
      if (fifo_push) ent_vld_q[wr_ptr_q] <= (lu_reg != 5'd0);
    end
  end

  // Payload storage. It is never read unless its valid bit is set, so it
  // needs no reset.
  // NOTE: keeping the memory out of the reset branch lets it map onto plain
  // storage without a reset mux on every bit.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      ent_reg_q[wr_ptr_q]  <= lu_reg;
      ent_data_q[wr_ptr_q] <= lu_data;
    end
  end

  assign RegWrite = we_q;
  assign regW     = waddr_q;
  assign Wdat     = wdata_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        Rst;
  logic        alu_we;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic [4:0]  qA, qB;
  logic        busyA, busyB;
  logic        RegWrite;
  logic [4:0]  regW;
  logic [31:0] Wdat;

  always #5 clk = ~clk;

  reg_writeback_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .alu_we   (alu_we),
    .alu_reg  (alu_reg),
    .alu_data (alu_data),
    .lu_valid (lu_valid),
    .lu_ready (lu_ready),
    .lu_reg   (lu_reg),
    .lu_data  (lu_data),
    .qA       (qA),
    .qB       (qB),
    .busyA    (busyA),
    .busyB    (busyB),
    .RegWrite (RegWrite),
    .regW     (regW),
    .Wdat     (Wdat)
  );

  // Reference model. The FIFO is an in-order list of results that are still
  // waiting; each one is either still wanted or already superseded.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic        v;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].v && mq[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check the
  // combinational outputs, move the model to the next state, then check
  // the registered outputs just after the rising edge.
  task automatic step(input logic rst, input logic awe, input logic [4:0] areg,
                      input logic [31:0] adata, input logic lv, input logic [4:0] lreg,
                      input logic [31:0] ldat, input logic [4:0] a, input logic [4:0] b);
    logic exp_ready, push, hit, byp;
    ent_t e;
    Rst = rst; alu_we = awe; alu_reg = areg; alu_data = adata;
    lu_valid = lv; lu_reg = lreg; lu_data = ldat; qA = a; qB = b;
    #1;
    exp_ready = (mq.size() < DEPTH);
    check("lu_ready", 32'(lu_ready), 32'(exp_ready));
    check("busyA",    32'(busyA),    32'(m_busy(a)));
    check("busyB",    32'(busyB),    32'(m_busy(b)));

    push = lv && exp_ready;
    hit  = awe && (areg != 5'd0);
    byp  = 1'b0;
`ifdef WB_BYPASS_EN
    byp = push && !hit && (mq.size() == 0) && (lreg != 5'd0);
`endif
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    end else begin
      if (hit) begin
        foreach (mq[i]) if (mq[i].r == areg) mq[i].v = 1'b0;
        m_we = 1'b1; m_reg = areg; m_data = adata;
      end else if (byp) begin
        m_we = 1'b1; m_reg = lreg; m_data = ldat;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = e.v;
        if (e.v) begin m_reg = e.r; m_data = e.d; end
      end else begin
        m_we = 1'b0;
      end
      if (push && !byp) mq.push_back('{r: lreg, d: ldat, v: (lreg != 5'd0)});
    end

    @(posedge clk);
    #1;
    check("RegWrite", 32'(RegWrite), 32'(m_we));
    check("regW",     32'(regW),     32'(m_reg));
    check("Wdat",     Wdat,          m_data);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [4:0] a, input logic [4:0] b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, b);
  endtask

  logic [4:0]  r_areg, r_lreg;
  logic [31:0] r_ldat;
  logic        r_lv;

  initial begin
    // Bring-up reset with nothing checked: the outputs are unknown until the
    // first clock edge.
    Rst = 1'b1; alu_we = 1'b0; alu_reg = '0; alu_data = '0;
    lu_valid = 1'b0; lu_reg = '0; lu_data = '0; qA = '0; qB = '0;
    m_we = 1'b0; m_reg = '0; m_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // 1: reset, then idle
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("rst_Wdat_zero", Wdat, 32'd0);
    idle(2, 5'd1, 5'd2);
    check("idle_ready", 32'(lu_ready), 32'd1);

    // 2: a single ALU write
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("alu_Wdat", Wdat, 32'hDEADBEEF);
    idle(1, 5'd5, 5'd0);
    check("alu_RegWrite_drop", 32'(RegWrite), 32'd0);

    // 3: a single long-latency push (qA=7 watches the queued entry)
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
    idle(3, 5'd7, 5'd7);

    // 4: fill the FIFO while the ALU holds the port, then let it drain
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b1, 5'd9, 32'h900 + 32'(i), 1'b1, 5'(i > 4 ? 4 : i), 32'h100 + 32'(i > 4 ? 4 : i), 5'd2, 5'd4);
    check("full_not_ready", 32'(lu_ready), 32'd0);
    idle(6, 5'd3, 5'd4);

    // 5: ALU write supersedes a queued result for the same register
    step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'hAA, 5'd3, 5'd0);
    step(1'b0, 1'b1, 5'd3, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    idle(3, 5'd3, 5'd0);

    // 6: push to r0, then reset with three entries queued
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);
    for (int i = 1; i <= 3; i++)
      step(1'b0, 1'b1, 5'd20, 32'd20, 1'b1, 5'(10 + i), 32'(i), 5'd11, 5'd13);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd13);
    idle(5, 5'd11, 5'd12);

    // Random traffic over a small register range so collisions are common.
    // The long-latency payload is held while the offer waits for ready.
    r_lv = 1'b0; r_lreg = '0; r_ldat = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!(r_lv && mq.size() >= DEPTH)) begin
        r_lv   = ($urandom_range(99) < 55);
        r_lreg = 5'($urandom_range(7));
        r_ldat = $urandom;
      end
      r_areg = 5'($urandom_range(7));
      step(($urandom_range(199) == 0), ($urandom_range(99) < 40), r_areg, $urandom,
           r_lv, r_lreg, r_ldat, 5'($urandom_range(7)), 5'($urandom_range(7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
